// File: rtl/ns_auth_monitor.sv
// Passive observer for the Needham-Schroeder-Lowe model: tracks runs and partners
// from net traffic and commit events, and flags authentication and secrecy violations.
module ns_auth_monitor #(
    parameter int NUM_INITIATORS = 2,
    parameter int NUM_RESPONDERS = 2,
    parameter int NUM_INTRUDERS  = 1,
    parameter int MSB            = 2,
    parameter int CNT_W          = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             msg_valid,
    input  logic [MSB:0]     msg_source,
    input  logic [MSB:0]     msg_dest,
    input  logic [MSB:0]     msg_key,
    input  logic [1:0]       msg_type,
    input  logic [MSB:0]     msg_nonce1,
    input  logic [MSB:0]     msg_nonce2,
    input  logic [MSB:0]     msg_address,
    input  logic             commit_valid,
    input  logic [MSB:0]     commit_agent,
    input  logic [MSB:0]     commit_partner,
    output logic             auth_fail,
    output logic             secrecy_fail,
    output logic [1:0]       fail_code,
    output logic [MSB:0]     fail_agent,
    output logic [CNT_W-1:0] msg_count,
    output logic [1:0]       mon_state
);

    localparam int NUM_HONEST = NUM_INITIATORS + NUM_RESPONDERS;
    localparam int NUM_AGENTS = NUM_HONEST + NUM_INTRUDERS;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FAIL = 2'd2} state_t;

    function automatic logic [MSB:0] agentId(input int k);
        return k[MSB:0];
    endfunction

    function automatic logic inRange(input logic [MSB:0] id);
        return int'(id) < NUM_AGENTS;
    endfunction

    function automatic logic isInit(input logic [MSB:0] id);
        return int'(id) < NUM_INITIATORS;
    endfunction

    function automatic logic isResp(input logic [MSB:0] id);
        return int'(id) >= NUM_INITIATORS && int'(id) < NUM_HONEST;
    endfunction

    function automatic logic isIntruder(input logic [MSB:0] id);
        return int'(id) >= NUM_HONEST && int'(id) < NUM_AGENTS;
    endfunction

    state_t                                        state_q;
    logic [NUM_INITIATORS-1:0][NUM_AGENTS-1:0]     started_q;
    logic [NUM_INITIATORS-1:0][MSB:0]              iPartner_q;
    logic [NUM_INITIATORS-1:0]                     ipv_q;
    logic [NUM_RESPONDERS-1:0][MSB:0]              rPartner_q;
    logic [NUM_RESPONDERS-1:0]                     rpv_q;
    logic [NUM_RESPONDERS-1:0]                     sentNna_q;
    logic [NUM_HONEST-1:0]                         leaked_q;
    logic [CNT_W-1:0]                              msgCount_q;
    logic                                          authFail_q;
    logic                                          secFail_q;
    logic [1:0]                                    failCode_q;
    logic [MSB:0]                                  failAgent_q;

    logic         msgOk;
    logic         commitOk;
    logic         authViolation;
    logic         secViolation;
    logic [MSB:0] secAgent;

    // A message or commit carrying any out-of-range ID is dropped entirely.
    assign msgOk = msg_valid && (msg_type != 2'd0) && inRange(msg_source) &&
                   inRange(msg_dest) && inRange(msg_key) && inRange(msg_nonce1) &&
                   inRange(msg_nonce2) && inRange(msg_address);
    assign commitOk = commit_valid && inRange(commit_agent) && inRange(commit_partner) &&
                      !isIntruder(commit_agent);

    always_comb begin
        authViolation = 1'b0;
        if (commitOk) begin
            if (state_q == IDLE) begin
                authViolation = 1'b1;
            end else if (isResp(commit_agent) && isInit(commit_partner)) begin
                for (int i = 0; i < NUM_INITIATORS; i++)
                    for (int p = NUM_INITIATORS; p < NUM_HONEST; p++)
                        if (commit_partner == agentId(i) && commit_agent == agentId(p) &&
                            !started_q[i][p])
                            authViolation = 1'b1;
            end else if (isInit(commit_agent) && isResp(commit_partner)) begin
                for (int r = 0; r < NUM_RESPONDERS; r++)
                    if (commit_partner == agentId(NUM_INITIATORS + r) &&
                        (!sentNna_q[r] || rPartner_q[r] != commit_agent))
                        authViolation = 1'b1;
            end
        end
    end

    // Scan from the highest honest ID down so the lowest leaked ID is reported.
    always_comb begin
        secViolation = 1'b0;
        secAgent     = '0;
        for (int r = NUM_RESPONDERS - 1; r >= 0; r--)
            if (leaked_q[NUM_INITIATORS + r] && rpv_q[r] && !isIntruder(rPartner_q[r])) begin
                secViolation = 1'b1;
                secAgent     = agentId(NUM_INITIATORS + r);
            end
        for (int i = NUM_INITIATORS - 1; i >= 0; i--)
            if (leaked_q[i] && ipv_q[i] && !isIntruder(iPartner_q[i])) begin
                secViolation = 1'b1;
                secAgent     = agentId(i);
            end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            started_q  <= '0;
            iPartner_q <= '0;
            ipv_q      <= '0;
            rPartner_q <= '0;
            rpv_q      <= '0;
            sentNna_q  <= '0;
            leaked_q   <= '0;
            msgCount_q <= '0;
        end else if (msgOk) begin
            if (msgCount_q != '1)
                msgCount_q <= msgCount_q + CNT_W'(1);
            if (msg_type == 2'd1 && msg_nonce1 == msg_source)
                for (int i = 0; i < NUM_INITIATORS; i++)
                    if (msg_source == agentId(i)) begin
                        for (int p = 0; p < NUM_AGENTS; p++)
                            if (msg_dest == agentId(p))
                                started_q[i][p] <= 1'b1;
                        iPartner_q[i] <= msg_dest;
                        ipv_q[i]      <= 1'b1;
                    end
            if (msg_type == 2'd2)
                for (int r = 0; r < NUM_RESPONDERS; r++)
                    if (msg_source == agentId(NUM_INITIATORS + r)) begin
                        rPartner_q[r] <= msg_dest;
                        rpv_q[r]      <= 1'b1;
                        sentNna_q[r]  <= 1'b1;
                    end
            if (isIntruder(msg_key) && !isIntruder(msg_source))
                for (int n = 0; n < NUM_HONEST; n++)
                    if (msg_nonce1 == agentId(n) || (msg_type == 2'd2 && msg_nonce2 == agentId(n)))
                        leaked_q[n] <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            authFail_q  <= 1'b0;
            secFail_q   <= 1'b0;
            failCode_q  <= 2'b00;
            failAgent_q <= '0;
        end else begin
            if (authViolation) authFail_q <= 1'b1;
            if (secViolation)  secFail_q  <= 1'b1;
            case (state_q)
                IDLE, RUN: begin
                    if (authViolation || secViolation) begin
                        state_q     <= FAIL;
                        failCode_q  <= {secViolation, authViolation};
                        failAgent_q <= authViolation ? commit_agent : secAgent;
                    end else if (msgOk) begin
                        state_q <= RUN;
                    end
                end
                default: state_q <= FAIL;
            endcase
        end
    end

    assign auth_fail    = authFail_q;
    assign secrecy_fail = secFail_q;
    assign fail_code    = failCode_q;
    assign fail_agent   = failAgent_q;
    assign msg_count    = msgCount_q;
    assign mon_state    = state_q;

endmodule

// File: tb/tb_ns_auth_monitor.sv
// Directed bench for ns_auth_monitor: honest run, attack shapes, races, saturation
// and asynchronous reset, each with hand-computed expected outputs.
module tb_ns_auth_monitor;

    logic       clock;
    logic       reset_n;
    logic       msg_valid;
    logic [2:0] msg_source, msg_dest, msg_key, msg_nonce1, msg_nonce2, msg_address;
    logic [1:0] msg_type;
    logic       commit_valid;
    logic [2:0] commit_agent, commit_partner;
    logic       auth_fail, secrecy_fail;
    logic [1:0] fail_code;
    logic [2:0] fail_agent;
    logic [7:0] msg_count;
    logic [1:0] mon_state;

    int checkCount = 0;
    int passCount  = 0;

    ns_auth_monitor dut (
        .clock(clock), .reset_n(reset_n),
        .msg_valid(msg_valid), .msg_source(msg_source), .msg_dest(msg_dest),
        .msg_key(msg_key), .msg_type(msg_type), .msg_nonce1(msg_nonce1),
        .msg_nonce2(msg_nonce2), .msg_address(msg_address),
        .commit_valid(commit_valid), .commit_agent(commit_agent),
        .commit_partner(commit_partner),
        .auth_fail(auth_fail), .secrecy_fail(secrecy_fail), .fail_code(fail_code),
        .fail_agent(fail_agent), .msg_count(msg_count), .mon_state(mon_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    endtask

    // Drives one cycle of message and commit inputs, then samples 1 time unit past the edge.
    task automatic applyStimulus(input logic mv, input logic [1:0] mt, input logic [2:0] src,
                                 input logic [2:0] dst, input logic [2:0] key,
                                 input logic [2:0] n1, input logic [2:0] n2,
                                 input logic [2:0] addr, input logic cv,
                                 input logic [2:0] ca, input logic [2:0] cp);
        msg_valid = mv; msg_type = mt; msg_source = src; msg_dest = dst; msg_key = key;
        msg_nonce1 = n1; msg_nonce2 = n2; msg_address = addr;
        commit_valid = cv; commit_agent = ca; commit_partner = cp;
        @(posedge clock);
        #1;
        msg_valid = 1'b0; commit_valid = 1'b0; msg_type = 2'd0;
    endtask

    task automatic sendMsg(input logic [1:0] mt, input logic [2:0] src, input logic [2:0] dst,
                           input logic [2:0] key, input logic [2:0] n1, input logic [2:0] n2,
                           input logic [2:0] addr);
        applyStimulus(1'b1, mt, src, dst, key, n1, n2, addr, 1'b0, 3'd0, 3'd0);
    endtask

    task automatic sendCommit(input logic [2:0] ca, input logic [2:0] cp);
        applyStimulus(1'b0, 2'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b1, ca, cp);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 2'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 3'd0);
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
    endtask

    task automatic honestRun(input string tag);
        sendMsg(2'd1, 3'd0, 3'd2, 3'd2, 3'd0, 3'd0, 3'd0);
        checkOutput({tag, " state after NA"}, mon_state, 1);
        sendCommit(3'd2, 3'd4);
        checkOutput({tag, " intruder-partner commit ok"}, auth_fail, 0);
        sendMsg(2'd2, 3'd2, 3'd0, 3'd0, 3'd0, 3'd2, 3'd2);
        sendMsg(2'd3, 3'd0, 3'd2, 3'd2, 3'd2, 3'd0, 3'd0);
        sendCommit(3'd2, 3'd0);
        checkOutput({tag, " responder commit ok"}, auth_fail, 0);
        sendCommit(3'd0, 3'd2);
        checkOutput({tag, " initiator commit ok"}, auth_fail, 0);
        idleCycle();
        checkOutput({tag, " secrecy"}, secrecy_fail, 0);
        checkOutput({tag, " count"}, msg_count, 3);
        checkOutput({tag, " state"}, mon_state, 1);
    endtask

    initial begin
        reset_n = 1'b0;
        msg_valid = 1'b0; msg_type = 2'd0; msg_source = '0; msg_dest = '0; msg_key = '0;
        msg_nonce1 = '0; msg_nonce2 = '0; msg_address = '0;
        commit_valid = 1'b0; commit_agent = '0; commit_partner = '0;
        #12;
        checkOutput("reset auth_fail", auth_fail, 0);
        checkOutput("reset secrecy_fail", secrecy_fail, 0);
        checkOutput("reset fail_code", fail_code, 0);
        checkOutput("reset fail_agent", fail_agent, 0);
        checkOutput("reset msg_count", msg_count, 0);
        checkOutput("reset mon_state", mon_state, 0);
        reset_n = 1'b1;

        honestRun("honest");

        doReset();
        sendMsg(2'd1, 3'd0, 3'd4, 3'd4, 3'd0, 3'd0, 3'd0);
        sendCommit(3'd2, 3'd0);
        checkOutput("lowe auth_fail", auth_fail, 1);
        checkOutput("lowe fail_code", fail_code, 1);
        checkOutput("lowe fail_agent", fail_agent, 2);
        checkOutput("lowe mon_state", mon_state, 2);
        idleCycle();
        checkOutput("lowe no secrecy", secrecy_fail, 0);
        sendMsg(2'd3, 3'd0, 3'd2, 3'd2, 3'd2, 3'd0, 3'd0);
        checkOutput("fail count continues", msg_count, 2);
        checkOutput("fail code held", fail_code, 1);
        checkOutput("fail state absorbing", mon_state, 2);

        doReset();
        sendMsg(2'd1, 3'd0, 3'd2, 3'd2, 3'd0, 3'd0, 3'd0);
        sendMsg(2'd2, 3'd2, 3'd4, 3'd4, 3'd0, 3'd2, 3'd2);
        checkOutput("secrecy not yet", secrecy_fail, 0);
        checkOutput("secrecy state run", mon_state, 1);
        idleCycle();
        checkOutput("secrecy_fail", secrecy_fail, 1);
        checkOutput("secrecy fail_code", fail_code, 2);
        checkOutput("secrecy fail_agent", fail_agent, 0);
        checkOutput("secrecy mon_state", mon_state, 2);
        checkOutput("secrecy no auth", auth_fail, 0);

        doReset();
        sendMsg(2'd3, 3'd0, 3'd2, 3'd2, 3'd2, 3'd0, 3'd0);
        applyStimulus(1'b1, 2'd1, 3'd0, 3'd2, 3'd2, 3'd0, 3'd0, 3'd0, 1'b1, 3'd2, 3'd0);
        checkOutput("race auth_fail", auth_fail, 1);
        checkOutput("race fail_agent", fail_agent, 2);
        checkOutput("race started[0][2]", dut.started_q[0][2], 1);

        doReset();
        sendMsg(2'd1, 3'd0, 3'd2, 3'd2, 3'd0, 3'd0, 3'd0);
        sendMsg(2'd2, 3'd2, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2);
        sendCommit(3'd0, 3'd2);
        checkOutput("init wrong partner auth", auth_fail, 1);
        checkOutput("init wrong partner agent", fail_agent, 0);

        doReset();
        sendCommit(3'd0, 3'd4);
        checkOutput("idle commit auth", auth_fail, 1);
        checkOutput("idle commit state", mon_state, 2);

        doReset();
        sendMsg(2'd0, 3'd0, 3'd2, 3'd2, 3'd2, 3'd0, 3'd0);
        checkOutput("type0 not counted", msg_count, 0);
        checkOutput("type0 stays idle", mon_state, 0);
        sendMsg(2'd3, 3'd5, 3'd2, 3'd2, 3'd2, 3'd0, 3'd0);
        checkOutput("out of range ignored", msg_count, 0);
        sendMsg(2'd3, 3'd0, 3'd2, 3'd2, 3'd2, 3'd0, 3'd0);
        checkOutput("first count", msg_count, 1);
        for (int k = 0; k < 253; k++) sendMsg(2'd3, 3'd0, 3'd2, 3'd2, 3'd2, 3'd0, 3'd0);
        checkOutput("count 254", msg_count, 254);
        for (int k = 0; k < 46; k++) sendMsg(2'd3, 3'd0, 3'd2, 3'd2, 3'd2, 3'd0, 3'd0);
        checkOutput("count saturated", msg_count, 255);
        sendMsg(2'd0, 3'd0, 3'd2, 3'd2, 3'd2, 3'd0, 3'd0);
        checkOutput("saturated type0", msg_count, 255);

        sendCommit(3'd2, 3'd0);
        checkOutput("pre-reset fail", mon_state, 2);
        #3;
        reset_n = 1'b0;
        #1;
        checkOutput("async auth_fail", auth_fail, 0);
        checkOutput("async secrecy_fail", secrecy_fail, 0);
        checkOutput("async fail_code", fail_code, 0);
        checkOutput("async fail_agent", fail_agent, 0);
        checkOutput("async msg_count", msg_count, 0);
        checkOutput("async mon_state", mon_state, 0);
        #1;
        reset_n = 1'b1;
        honestRun("post-reset");

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/ns_auth_monitor.md
Name: ns_auth_monitor

Overview:
- Observer stage directly downstream of the Needham-Schroeder-Lowe protocol model.
- Consumes every message the protocol places on the shared net, plus the agent commit events.
- Keeps run and partner bookkeeping, and raises sticky authentication and secrecy violation flags for the model checker and simulation benches.
- Purely passive: it never drives the net.

Parameters:
- NUM_INITIATORS, 2, initiator agent IDs 0..NUM_INITIATORS-1
- NUM_RESPONDERS, 2, responder IDs follow the initiators (2..3)
- NUM_INTRUDERS, 1, intruder IDs follow the responders (4)
- MSB, 2, MSB of agent/nonce ID fields
- CNT_W, 8, message counter width

Ports:
- clock  in  1  single clock, posedge
- reset_n  in  1  asynchronous, active-low reset
- msg_valid  in  1  one-cycle pulse: new message on the net this cycle
- msg_source  in  MSB+1  sender ID
- msg_dest  in  MSB+1  intended destination
- msg_key  in  MSB+1  encryption key (owner ID)
- msg_type  in  2  0=NoMessage, 1=NonceAddress, 2=NonceNonceAddress, 3=Nonce
- msg_nonce1  in  MSB+1  first nonce
- msg_nonce2  in  MSB+1  second nonce/ID
- msg_address  in  MSB+1  sender identifier field
- commit_valid  in  1  pulse: an honest agent enters COMMITTED
- commit_agent  in  MSB+1  committing agent
- commit_partner  in  MSB+1  partner recorded by that agent
- auth_fail  out  1  sticky authentication violation
- secrecy_fail  out  1  sticky nonce-secrecy violation
- fail_code  out  2  first violation: 01 auth, 10 secrecy, 11 both on same edge
- fail_agent  out  MSB+1  agent involved in the first violation
- msg_count  out  CNT_W  saturating count of accepted messages
- mon_state  out  2  0=IDLE, 1=RUN, 2=FAIL

Behaviour:
- Reset (async, reset_n=0): all outputs 0; all tables cleared; mon_state=IDLE.
- Agent class: an ID at or above the total agent count (5) is out of range. Any input event carrying an out-of-range ID is ignored entirely.
- Accepted message: msg_valid=1 and msg_type!=0. Each one increments msg_count, which saturates at 2^CNT_W-1.
- Run table started[i][p] (bit per initiator/partner):
  - Set on an accepted NonceAddress with source=initiator i, nonce1=i, dest=p.
  - The same message also loads ipartner[i]=p and sets ipv[i].
- Responder partner: an accepted NonceNonceAddress from responder r loads rpartner[r]=dest, sets rpv[r] and sets sent_nna[r].
- Leak tracking:
  - Applies to an accepted message with key=intruder and source not an intruder.
  - Set leaked[nonce1] if nonce1 is an honest ID.
  - For NonceNonceAddress, also set leaked[nonce2] if nonce2 is an honest ID.
- Auth check (combinational on registered tables, result registered at the same edge):
  - Responder commit with partner initiator i fails when started[i][commit_agent]=0.
  - Initiator commit with a responder partner r fails when sent_nna[r]=0 or rpartner[r]!=commit_agent.
  - Commits naming an intruder partner never fail.
- Secrecy check:
  - Each cycle, evaluate OR over honest n of leaked[n] && partner_valid(n) && partner(n) not an intruder.
  - partner(n) is ipartner[n] for initiators and rpartner[n] for responders.
  - The result is registered. secrecy_fail therefore rises one edge after the leaking message's capture edge.
- Simultaneous events: a commit and a message in the same cycle are checked against pre-update tables. Tables update at the same edge.
- FSM:
  - IDLE→RUN on the first accepted message.
  - IDLE/RUN→FAIL on any violation. A commit in IDLE always fails auth.
  - FAIL is absorbing until reset. Table and counter updates continue in FAIL.
- First-capture: fail_code and fail_agent load only on the edge that enters FAIL.
  - fail_agent is commit_agent for auth.
  - fail_agent is the lowest leaked honest n for secrecy.
- Reset mid-operation clears everything immediately, regardless of FSM state.

Test Plan:
- Honest run:
  - Stimulus: NA(0→2, key2, n1=0, n2=0, addr0); NNA(2→0, key0, n1=0, n2=2, addr2); Nonce(0→2, key2, n1=2); then commit(agent2, partner0).
  - Required: no fail, msg_count=3, mon_state=1.
- Lowe attack shape:
  - Stimulus: NA(0→4, key4); responder 2 commits with partner 0.
  - Required: at that edge auth_fail=1, fail_code=01, fail_agent=2, mon_state=2.
- Secrecy:
  - Stimulus: NA(0→2, key2); then NNA(2→4, key4, n1=0, n2=2).
  - Required: one edge after the second capture, secrecy_fail=1, fail_code=10, fail_agent=0. Responder 2's own nonce is not a violation because its partner is 4.
- Same-cycle race:
  - Stimulus: commit(2, partner0) in the same cycle as NA(0→2).
  - Required: auth_fail=1 (old table used); started[0][2] is still set.
- Saturation:
  - Stimulus: 300 accepted messages.
  - Required: msg_count=255. msg_valid with msg_type=0 does not count.
- Async reset:
  - Stimulus: drive reset_n low mid-clock while in FAIL.
  - Required: all outputs 0 without a clock edge. After release, a fresh honest run passes.
